// File: rtl/bram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter_pkg
// Brief    : Shared memory-subsystem constants, FSM encodings and arbitration
//            helpers for the block-RAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam int unsigned MEM_DATA_WIDTH = 32;
    localparam int unsigned MEM_ADDR_WIDTH = 10;
    localparam int unsigned MEM_DEPTH      = 1 << MEM_ADDR_WIDTH;

    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;

    // On a tie the requester that did not win last time is chosen.
    function automatic logic rr_winner(input logic req0, input logic req1,
                                       input logic last);
        logic win;
        if (req0 && req1)
            win = ~last;
        else if (req1)
            win = GRANT_M1;
        else
            win = GRANT_M0;
        return win;
    endfunction

    function automatic logic fixed_winner(input logic req0, input logic req1);
        logic win;
        if (req0)
            win = GRANT_M0;
        else if (req1)
            win = GRANT_M1;
        else
            win = GRANT_M0;
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter
// Brief    : Two-requester arbiter driving one port of a dual-port block RAM
//            (IDLE -> ACCESS -> RESP). Define ARB_ROUND_ROBIN_EN for
//            round-robin arbitration; otherwise requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int data_size = 32,
    parameter int addr_size = 10
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 m0_req,
    input  logic                 m0_wr,
    input  logic [addr_size-1:0] m0_addr,
    input  logic [data_size-1:0] m0_din,
    output logic [data_size-1:0] m0_dout,
    output logic                 m0_ack,

    input  logic                 m1_req,
    input  logic                 m1_wr,
    input  logic [addr_size-1:0] m1_addr,
    input  logic [data_size-1:0] m1_din,
    output logic [data_size-1:0] m1_dout,
    output logic                 m1_ack,

    output logic                 mem_wr,
    output logic [addr_size-1:0] mem_addr,
    output logic [data_size-1:0] mem_din,
    input  logic [data_size-1:0] mem_dout
);

    arb_state_e           state_q;
    logic                 grant_q;
    logic                 m0_ack_q;
    logic                 m1_ack_q;
    logic [data_size-1:0] m0_dout_q;
    logic [data_size-1:0] m1_dout_q;
    logic                 winner_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic                 last_q;

    always_comb begin
        winner_d = rr_winner(m0_req, m1_req, last_q);
    end
`else
    always_comb begin
        winner_d = fixed_winner(m0_req, m1_req);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= GRANT_M0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            m0_dout_q <= '0;
            m1_dout_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= GRANT_M1;
`endif
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        grant_q <= winner_d;
`ifdef ARB_ROUND_ROBIN_EN
                        last_q  <= winner_d;
`endif
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_q <= RESP;
                end
                RESP: begin
                    // RAM output now reflects the address presented in ACCESS.
                    if (grant_q == GRANT_M1) begin
                        m1_ack_q  <= 1'b1;
                        m1_dout_q <= mem_dout;
                    end else begin
                        m0_ack_q  <= 1'b1;
                        m0_dout_q <= mem_dout;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory port is driven only in ACCESS, so an async reset kills a write at once.
    always_comb begin
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (state_q == ACCESS) begin
            if (grant_q == GRANT_M1) begin
                mem_wr   = m1_wr;
                mem_addr = m1_addr;
                mem_din  = m1_din;
            end else begin
                mem_wr   = m0_wr;
                mem_addr = m0_addr;
                mem_din  = m0_din;
            end
        end
    end

    assign m0_ack  = m0_ack_q;
    assign m1_ack  = m1_ack_q;
    assign m0_dout = m0_dout_q;
    assign m1_dout = m1_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_port_arbiter
// Brief    : Directed self-checking bench for bram_port_arbiter with a
//            behavioural write-first registered-address RAM on the mem_* port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk;
    logic          rst;
    logic          m0_req, m0_wr, m1_req, m1_wr;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_din, m1_din, m0_dout, m1_dout;
    logic          m0_ack, m1_ack;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] ram [0:(1<<AW)-1];

    int n_checks;
    int n_fail;

    bram_port_arbiter #(.data_size(DW), .addr_size(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_wr    (m0_wr),
        .m0_addr  (m0_addr),
        .m0_din   (m0_din),
        .m0_dout  (m0_dout),
        .m0_ack   (m0_ack),
        .m1_req   (m1_req),
        .m1_wr    (m1_wr),
        .m1_addr  (m1_addr),
        .m1_din   (m1_din),
        .m1_dout  (m1_dout),
        .m1_ack   (m1_ack),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first RAM with registered address; pre_* is a bench-only preload path.
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_wr) begin
            ram[mem_addr] <= mem_din;
            mem_dout      <= mem_din;
        end else begin
            mem_dout      <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transfer starting from IDLE with requests already applied.
    task automatic transfer(input string tag, input logic exp_ack0, input logic exp_ack1,
                            input logic [31:0] exp_dout);
        tick();
        tick();
        tick();
        check({tag, "_ack0"}, {31'd0, m0_ack}, {31'd0, exp_ack0});
        check({tag, "_ack1"}, {31'd0, m1_ack}, {31'd0, exp_ack1});
        check({tag, "_dout"}, exp_ack1 ? m1_dout : m0_dout, exp_dout);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_din = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_din = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        // Preload during reset
        pre_we = 1'b1; pre_addr = 10'h005; pre_data = 32'hDEADBEEF;
        tick();
        pre_addr = 10'h0AA; pre_data = 32'h00000055;
        tick();
        pre_we = 1'b0;
        tick();
        check("rst_m0_ack",  {31'd0, m0_ack}, 32'd0);
        check("rst_m1_ack",  {31'd0, m1_ack}, 32'd0);
        check("rst_m0_dout", m0_dout, 32'd0);
        check("rst_m1_dout", m1_dout, 32'd0);
        check("rst_mem_wr",  {31'd0, mem_wr}, 32'd0);
        rst = 1'b0;
        tick();

        // Single read by m0
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 10'h005;
        tick();
        check("rd_access_addr", {22'd0, mem_addr}, 32'h005);
        check("rd_access_wr",   {31'd0, mem_wr}, 32'd0);
        check("rd_access_ack",  {31'd0, m0_ack}, 32'd0);
        tick();
        check("rd_resp_ack",    {31'd0, m0_ack}, 32'd0);
        tick();
        check("rd_ack0",  {31'd0, m0_ack}, 32'd1);
        check("rd_ack1",  {31'd0, m1_ack}, 32'd0);
        check("rd_dout0", m0_dout, 32'hDEADBEEF);
        m0_req = 1'b0;
        tick();
        check("rd_ack_one_cycle", {31'd0, m0_ack}, 32'd0);
        tick();

        // m1 write then back-to-back read of the same address
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 10'h3FF; m1_din = 32'h12345678;
        tick();
        check("wr_mem_wr",   {31'd0, mem_wr}, 32'd1);
        check("wr_mem_addr", {22'd0, mem_addr}, 32'h3FF);
        check("wr_mem_din",  mem_din, 32'h12345678);
        tick();
        check("wr_mem_wr_one_cycle", {31'd0, mem_wr}, 32'd0);
        tick();
        check("wr_ack1", {31'd0, m1_ack}, 32'd1);
        check("wr_ack0", {31'd0, m0_ack}, 32'd0);
        m1_wr = 1'b0;
        tick();
        check("rd2_mem_wr",   {31'd0, mem_wr}, 32'd0);
        check("rd2_mem_addr", {22'd0, mem_addr}, 32'h3FF);
        check("rd2_ack_low",  {31'd0, m1_ack}, 32'd0);
        tick();
        tick();
        check("rd2_ack1",  {31'd0, m1_ack}, 32'd1);
        check("rd2_dout1", m1_dout, 32'h12345678);
        check("rd2_dout0_hold", m0_dout, 32'hDEADBEEF);
        m1_req = 1'b0;
        tick();

        // Contention: both requesters hold req
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 10'h005;
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 10'h3FF;
`ifdef ARB_ROUND_ROBIN_EN
        transfer("rr_t1", 1'b1, 1'b0, 32'hDEADBEEF);
        transfer("rr_t2", 1'b0, 1'b1, 32'h12345678);
        transfer("rr_t3", 1'b1, 1'b0, 32'hDEADBEEF);
        transfer("rr_t4", 1'b0, 1'b1, 32'h12345678);
`else
        transfer("fp_t1", 1'b1, 1'b0, 32'hDEADBEEF);
        transfer("fp_t2", 1'b1, 1'b0, 32'hDEADBEEF);
        transfer("fp_t3", 1'b1, 1'b0, 32'hDEADBEEF);
        transfer("fp_t4", 1'b1, 1'b0, 32'hDEADBEEF);
`endif
        m0_req = 1'b0;
        transfer("cont_m1_after_m0", 1'b0, 1'b1, 32'h12345678);
        m1_req = 1'b0;
        tick();
        check("cont_idle_ack1", {31'd0, m1_ack}, 32'd0);

        // Dropped request: m1 releases req right after grant
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 10'h005;
        tick();
        m1_req = 1'b0;
        tick();
        tick();
        check("drop_ack1",  {31'd0, m1_ack}, 32'd1);
        check("drop_dout1", m1_dout, 32'hDEADBEEF);
        check("drop_ack0",  {31'd0, m0_ack}, 32'd0);
        tick();
        check("drop_ack1_once", {31'd0, m1_ack}, 32'd0);
        tick();
        check("drop_idle_ack1", {31'd0, m1_ack}, 32'd0);
        check("drop_idle_addr", {22'd0, mem_addr}, 32'd0);

        // Reset mid-write: reset lands between clock edges
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 10'h0AA; m0_din = 32'h00000001;
        tick();
        check("rstw_mem_wr_before", {31'd0, mem_wr}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstw_mem_wr",   {31'd0, mem_wr}, 32'd0);
        check("rstw_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("rstw_mem_din",  mem_din, 32'd0);
        check("rstw_m0_dout",  m0_dout, 32'd0);
        check("rstw_m1_dout",  m1_dout, 32'd0);
        check("rstw_ack0",     {31'd0, m0_ack}, 32'd0);
        check("rstw_ack1",     {31'd0, m1_ack}, 32'd0);
        m0_req = 1'b0; m0_wr = 1'b0;
        tick();
        tick();
        check("rstw_no_ack", {31'd0, m0_ack}, 32'd0);
        rst = 1'b0;
        tick();

        // First arbitration after reset favours m0; 0x0AA must be unchanged
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 10'h0AA;
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 10'h005;
        transfer("post_rst_first", 1'b1, 1'b0, 32'h00000055);
        m0_req = 1'b0;
        transfer("post_rst_m1", 1'b0, 1'b1, 32'hDEADBEEF);
        m1_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
